// File: rtl/barcode_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : barcode_tx_if
// Description : Request/status bundle for the barcode_tx serializer.
//               The rpt line exists only when BARCODE_TX_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface barcode_tx_if #(
  parameter int QW = 20
);
  logic          send;
  logic [7:0]    ID_in;
  logic [QW-1:0] qtr;
  logic          BC;
  logic          busy;
  logic          done;
`ifdef BARCODE_TX_REPEAT_EN
  logic          rpt;
`endif

  // Requester side: drives the frame request, observes the line and status
  modport master (
    output send, ID_in, qtr,
`ifdef BARCODE_TX_REPEAT_EN
    output rpt,
`endif
    input  BC, busy, done
  );

  // Serializer side
  modport slave (
    input  send, ID_in, qtr,
`ifdef BARCODE_TX_REPEAT_EN
    input  rpt,
`endif
    output BC, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/barcode_tx.sv
`default_nettype none
// ============================================================================
// Module      : barcode_tx
// Description : Single-wire barcode serializer. Sends a start bit (2Q low,
//               2Q high), eight pulse-width-encoded bits MSB first (1: Q low
//               3Q high, 0: 3Q low Q high) and a 4Q high guard gap.
//               Optional macro BARCODE_TX_REPEAT_EN adds the rpt input that
//               chains frames back to back without an IDLE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module barcode_tx #(
  parameter int QW    = 20,
  parameter int MIN_Q = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  barcode_tx_if.slave  bus
);

  localparam int TW = QW + 2;  // 4*Qe-1 always fits in QW+2 bits

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START_LO = 3'd1;
  localparam logic [2:0] S_START_HI = 3'd2;
  localparam logic [2:0] S_BIT_LO   = 3'd3;
  localparam logic [2:0] S_BIT_HI   = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam logic [QW-1:0] C_MIN_Q = QW'(MIN_Q);
  localparam logic [TW-1:0] C_ONE   = TW'(1);

  logic [2:0]    state_q,  state_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [QW-1:0] qe_q,     qe_d;
  logic [7:0]    shift_q,  shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic          bc_q,     bc_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
`ifdef BARCODE_TX_REPEAT_EN
  logic [7:0]    id_q,     id_d;
`endif

  // Segment lengths: in IDLE the request's clamped Q is used directly so the
  // first segment can be loaded on the accepting edge; otherwise the latched Q.
  logic [QW-1:0] w_qe_in;
  logic [QW-1:0] w_qsel;
  logic [TW-1:0] w_q1, w_q2, w_q3, w_q4;
  logic          w_tz;

  assign w_qe_in = (bus.qtr < C_MIN_Q) ? C_MIN_Q : bus.qtr;
  assign w_qsel  = (state_q == S_IDLE) ? w_qe_in : qe_q;
  assign w_q1    = {2'b00, w_qsel};
  assign w_q2    = {1'b0, w_qsel, 1'b0};
  assign w_q4    = {w_qsel, 2'b00};
  assign w_q3    = w_q1 + w_q2;
  assign w_tz    = (timer_q == '0);

  // Frame sequencer: each segment loads N-1 and advances when the timer hits 0
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    qe_d     = qe_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    bc_d     = bc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef BARCODE_TX_REPEAT_EN
    id_d     = id_q;
`endif
    case (state_q)
      S_IDLE: begin
        bc_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.send) begin
          qe_d     = w_qe_in;
          shift_d  = bus.ID_in;
`ifdef BARCODE_TX_REPEAT_EN
          id_d     = bus.ID_in;
`endif
          bitcnt_d = 4'd0;
          timer_d  = w_q2 - C_ONE;
          bc_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_START_LO;
        end
      end
      S_START_LO: begin
        if (w_tz) begin
          state_d = S_START_HI;
          bc_d    = 1'b1;
          timer_d = w_q2 - C_ONE;
        end else begin
          timer_d = timer_q - C_ONE;
        end
      end
      S_START_HI: begin
        if (w_tz) begin
          state_d = S_BIT_LO;
          bc_d    = 1'b0;
          timer_d = shift_q[7] ? (w_q1 - C_ONE) : (w_q3 - C_ONE);
        end else begin
          timer_d = timer_q - C_ONE;
        end
      end
      S_BIT_LO: begin
        if (w_tz) begin
          state_d = S_BIT_HI;
          bc_d    = 1'b1;
          timer_d = shift_q[7] ? (w_q3 - C_ONE) : (w_q1 - C_ONE);
        end else begin
          timer_d = timer_q - C_ONE;
        end
      end
      S_BIT_HI: begin
        if (w_tz) begin
          shift_d  = {shift_q[6:0], 1'b0};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            state_d = S_GAP;
            bc_d    = 1'b1;
            timer_d = w_q4 - C_ONE;
          end else begin
            // shift_q[6] becomes the next bit after this edge's shift
            state_d = S_BIT_LO;
            bc_d    = 1'b0;
            timer_d = shift_q[6] ? (w_q1 - C_ONE) : (w_q3 - C_ONE);
          end
        end else begin
          timer_d = timer_q - C_ONE;
        end
      end
      S_GAP: begin
        if (w_tz) begin
          done_d = 1'b1;
`ifdef BARCODE_TX_REPEAT_EN
          if (bus.rpt) begin
            state_d  = S_START_LO;
            shift_d  = id_q;
            bitcnt_d = 4'd0;
            timer_d  = w_q2 - C_ONE;
            bc_d     = 1'b0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
`endif
        end else begin
          timer_d = timer_q - C_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        bc_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the line high immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      qe_q     <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      bc_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BARCODE_TX_REPEAT_EN
      id_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      qe_q     <= qe_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      bc_q     <= bc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef BARCODE_TX_REPEAT_EN
      id_q     <= id_d;
`endif
    end
  end

  assign bus.BC   = bc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: doc/barcode_tx.md
Name: barcode_tx

Overview:
- Upstream serializer: encodes an 8-bit station ID onto the single-wire BC line in the format the barcode reader decodes.
- Used as the stimulus generator in reader benches and as the BC source on the test fixture.
- Transmits a start bit, then 8 pulse-width-encoded data bits MSB first, then a high guard gap.
- Bit timing derives from a programmable quarter-period count.

Parameters:
QW, 20, width of the quarter-period input in clocks
MIN_Q, 4, minimum effective quarter period; smaller requests are clamped up to it

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
send  input  1  start request; sampled only in IDLE
ID_in  input  8  ID to transmit; latched on accepted send
qtr  input  QW  quarter bit period Q in clocks; latched on accepted send
BC  output  1  serial barcode line, idle high, registered
busy  output  1  high from the cycle after an accepted send through the end of GAP
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk.
- Reset values: BC=1, busy=0, done=0, state=IDLE, shift/latch registers and timer=0.
- Reset mid-frame aborts immediately: BC returns to 1 with no partial-bit glitch beyond the reset edge.
- Effective Q (Qe) = max(qtr, MIN_Q), latched. The segment timer is QW+2 bits wide, so 3*Qe never overflows.
- Segment rule: each segment holds BC at its level for exactly N clocks. Timer loads N-1, counts down, and advances state at 0.
- States and segments:
  - IDLE: BC=1. Send=1 latches ID_in/Qe and moves to START_LO; BC falls on the next clock edge.
  - START_LO: BC=0 for 2Qe. The reader measures this as the half period.
  - START_HI: BC=1 for 2Qe.
  - BIT_LO: BC=0 for Qe if the current bit is 1, 3Qe if it is 0.
  - BIT_HI: BC=1 for 3Qe if the bit is 1, Qe if it is 0. Each bit period is therefore 4Qe, and the reader samples at ~2Qe after the falling edge.
  - Bit order: MSB first; the shift register shifts left at the end of BIT_HI. After 8 bits, go to GAP.
  - GAP: BC=1 for 4Qe, then return to IDLE.
- Frame length from the first BC fall to the end of GAP is 40*Qe clocks.
- done=1 for the single cycle the FSM enters IDLE from GAP; busy=0 in that same cycle.
- Simultaneous events:
  - send is accepted in the cycle done is high (back-to-back frames); BC stays high for only that one IDLE cycle before the next start.
  - send while busy is ignored, not queued. ID_in and qtr changes during a frame have no effect.
- Bit counter is 4 bits, 0..8. GAP is entered when the counter reaches 8.

Optional Feature:
- Macro BARCODE_TX_REPEAT_EN.
- Defined: adds input port rpt (1 bit). At the end of GAP, if rpt=1, the FSM goes directly to START_LO with the same latched ID/Qe. done still pulses for one cycle, busy stays 1, and no IDLE cycle is inserted. With rpt=0, behaviour matches the undefined case.
- Undefined: port rpt is absent; every frame needs its own send.

Test Plan:
- Reset, then send ID_in=0xA5, qtr=4:
  - BC low 8, high 8.
  - Bit 1: low 4, high 12. Bit 0: low 12, high 4. Pattern 1,0,1,0,0,1,0,1.
  - Gap high 16; done pulses at clock 160 after the first fall.
- qtr=1, ID_in=0xFF: timing identical to qtr=4, i.e. clamped to MIN_Q. Every bit low 4, high 12.
- Loopback to the barcode reader with ID_in=0x3C, qtr=16: reader ID_vld rises with ID=0x3C. Repeat with 0x00 and 0xFF, both decoded exactly.
- Send 0x11 then pulse send with 0x22 mid-frame: only 0x11 is transmitted. Send 0x22 in the done cycle: second frame starts next edge and decodes 0x22.
- Assert rst_n=0 during bit 3 of 0xC3: BC=1, busy=0, done=0 immediately. A new send of 0x5A afterwards decodes correctly.
- With BARCODE_TX_REPEAT_EN and rpt=1, send 0x81, qtr=4: frames repeat every 160 clocks, done pulses each frame, busy stays 1. Dropping rpt ends after the current frame.
